cond_flags_unit: RTL
====================

COND_FLAGS_UNIT -- requirements
Module: cond_flags_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the skipped-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alu_flags  input  4  flags from the same-cycle ALU op, order (Z)(N)(C)(V): [3]=Z [2]=N [1]=C [0]=V.
REQ-005 flags_we  input  1  the current instruction requests a flag update (S bit).
REQ-006 cond  input  4  condition code of the current instruction.
REQ-007 instr_valid  input  1  the current-cycle instruction is valid.
REQ-008 stall  input  1  pipeline stall; freezes all state.
REQ-009 clr_count  input  1  synchronous clear of skip_count.
REQ-010 flags_q  output  4  architectural flag register, same (Z)(N)(C)(V) order.
REQ-011 cond_pass  output  1  registered: the previous accepted instruction passed its condition.
REQ-012 exec_en  output  1  registered: the previous accepted instruction is valid and shall commit.
REQ-013 flags_upd  output  1  registered one-cycle pulse: flags_q was written at the last edge.
REQ-014 skip_count  output  CNT_W  saturating count of valid instructions that failed their condition.

Function
REQ-015 The condition is evaluated combinationally against the current flags_q, never against alu_flags.
REQ-016 Condition table: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
REQ-017 Condition table continued: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
REQ-018 A cycle is accepted when stall=0; all registers hold their value when stall=1.
REQ-019 On an accepted cycle, cond_pass <= pass; exec_en <= instr_valid & pass. Latency is one cycle.
REQ-020 On an accepted cycle with instr_valid=0: cond_pass <= 0, exec_en <= 0, flags_upd <= 0, and flags_q and skip_count hold.
REQ-021 flags_q <= alu_flags only when accepted & instr_valid & pass & flags_we; flags_upd <= that same term.
REQ-022 A failing condition with flags_we=1 shall leave flags_q unchanged.
REQ-023 Back-to-back instructions: the instruction at cycle t+1 evaluates against the flags written at the t/t+1 edge.
REQ-024 skip_count increments by 1 on each accepted cycle with instr_valid & !pass, and saturates at 2^CNT_W-1.
REQ-025 clr_count=1 clears skip_count to 0 regardless of stall or an increment in the same cycle.
REQ-026 flags_upd is a single-cycle pulse unless consecutive accepted writes occur.
REQ-027 The block has no combinational path from any input to any output.

Reset
REQ-028 With rst=1 at an edge: flags_q=0000, cond_pass=0, exec_en=0, flags_upd=0, skip_count=0.
REQ-029 rst takes priority over stall, clr_count and any in-flight flag write.
REQ-030 Reset mid-operation discards the pending evaluation; all outputs are at reset values on the first cycle after the reset edge.

Verification
REQ-031 Reset, then cond=0000 (EQ), instr_valid=1, flags_we=1, alu_flags=1000 -> next cycle: cond_pass=0, exec_en=0, flags_q=0000, skip_count=1.
REQ-032 cond=1110 (AL), flags_we=1, alu_flags=1000, then cond=0000 in the next cycle -> flags_q=1000 with flags_upd=1, then exec_en=1 for the EQ instruction.
REQ-033 flags_q=0101 (N=1,V=1): GE -> pass, LT -> fail, GT -> pass; flags_q=0100: GE -> fail, LE -> pass, NV -> fail.
REQ-034 stall=1 for 3 cycles with a valid, flag-setting AL instruction -> flags_q, exec_en and skip_count unchanged; the first cycle after stall drops applies the update.
REQ-035 Force 2^CNT_W+2 consecutive failing instructions -> skip_count=all ones; clr_count=1 at the same time as a failing instruction -> skip_count=0.
REQ-036 rst=1 with stall=1 and a valid AL flag-write pending -> all outputs at reset values after the edge, and flags_q=0000.

Source files
------------

// File: rtl/cond_flags_unit.sv
// cond_flags_unit
// Holds the architectural Z/N/C/V flag register and decides whether the current
// instruction executes, based on its condition code and the flags already held.
// Every output is a register, so there is no combinational path from any input
// to any output. A stall freezes all state except the skip-counter clear.
// Flag order everywhere is [3]=Z [2]=N [1]=C [0]=V.

module cond_flags_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       alu_flags,
    input  logic             flags_we,
    input  logic [3:0]       cond,
    input  logic             instr_valid,
    input  logic             stall,
    input  logic             clr_count,
    output logic [3:0]       flags_q,
    output logic             cond_pass,
    output logic             exec_en,
    output logic             flags_upd,
    output logic [CNT_W-1:0] skip_count
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    logic flag_z;
    logic flag_n;
    logic flag_c;
    logic flag_v;
    logic pass;
    logic accept;
    logic commit;
    logic write_flags;
    logic skip_inc;

    // The condition looks only at the registered flags, so an instruction never
    // sees the flags produced by its own ALU operation.
    assign flag_z = flags_q[3];
    assign flag_n = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    assign accept      = !stall;
    assign commit      = accept && instr_valid && pass;
    assign write_flags = commit && flags_we;
    assign skip_inc    = accept && instr_valid && !pass;

    // Decode the condition code against the held flags.
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = flag_z;
            COND_NE: pass = !flag_z;
            COND_CS: pass = flag_c;
            COND_CC: pass = !flag_c;
            COND_MI: pass = flag_n;
            COND_PL: pass = !flag_n;
            COND_VS: pass = flag_v;
            COND_VC: pass = !flag_v;
            COND_HI: pass = flag_c && !flag_z;
            COND_LS: pass = !flag_c || flag_z;
            COND_GE: pass = (flag_n == flag_v);
            COND_LT: pass = (flag_n != flag_v);
            COND_GT: pass = !flag_z && (flag_n == flag_v);
            COND_LE: pass = flag_z || (flag_n != flag_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

    // Flag register and per-instruction status; everything holds while stalled.
    // An idle cycle (instr_valid=0) still clears the status bits because the
    // evaluation it reports on belongs to no instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q   <= 4'b0000;
            cond_pass <= 1'b0;
            exec_en   <= 1'b0;
            flags_upd <= 1'b0;
        end else if (accept) begin
            cond_pass <= instr_valid && pass;
            exec_en   <= commit;
            flags_upd <= write_flags;
            if (write_flags) begin
                flags_q <= alu_flags;
            end
        end
    end

    // Saturating count of skipped instructions; the clear works even during a
    // stall and wins over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_count <= '0;
        end else if (clr_count) begin
            skip_count <= '0;
        end else if (skip_inc && (skip_count != {CNT_W{1'b1}})) begin
            skip_count <= skip_count + CNT_W'(1);
        end
    end

endmodule
